sig_analyzer: RTL

//  Downstream response compactor for the gate-level circuit under test (CUT).

---
 rtl/sig_analyzer_pkg.sv | 19 +
 rtl/sig_analyzer_if.sv | 35 +++
 rtl/sig_analyzer_sisr_reg.sv | 34 +++
 rtl/sig_analyzer.sv | 97 +++++++++
 4 files changed

// File: rtl/sig_analyzer_pkg.sv
// Shared types and SISR step function for the signature analyzer.
// The step function works on 64-bit words, so SIG_W may be at most 64.
package sig_analyzer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, COMPARE, DONE} state_e;

  localparam int          SIG_W_DEF = 16;
  localparam int          CNT_W_DEF = 8;
  localparam logic [15:0] POLY_DEF  = 16'h1021;
  localparam logic [15:0] SEED_DEF  = 16'hFFFF;

  // One SISR step; the caller supplies fb = msb ^ din and truncates to its width.
  function automatic logic [63:0] sisr_next(input logic [63:0] sig,
                                            input logic        fb,
                                            input logic [63:0] poly);
    return (sig << 1) ^ (fb ? poly : 64'd0);
  endfunction

endpackage

// File: rtl/sig_analyzer_if.sv
// Control/response bus of the signature analyzer (master drives, slave is the analyzer).
// SIG_ANALYZER_ABORT_EN adds the abort request line.
interface sig_analyzer_if #(
  parameter int SIG_W = 16,
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] num_patterns;
  logic             resp_valid;
  logic             resp_bit;
  logic [SIG_W-1:0] golden_sig;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;
`ifdef SIG_ANALYZER_ABORT_EN
  logic             abort;
`endif

  modport master (
`ifdef SIG_ANALYZER_ABORT_EN
    output abort,
`endif
    output start, num_patterns, resp_valid, resp_bit, golden_sig,
    input  busy, done, pass, signature
  );

  modport slave (
`ifdef SIG_ANALYZER_ABORT_EN
    input  abort,
`endif
    input  start, num_patterns, resp_valid, resp_bit, golden_sig,
    output busy, done, pass, signature
  );
endinterface

// File: rtl/sig_analyzer_sisr_reg.sv
// Serial-input signature register: reloads SEED on load_seed, compacts din on shift_en.
module sisr_reg
  import sig_analyzer_pkg::*;
#(
  parameter int               SIG_W = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(SEED_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_seed,
  input  logic             shift_en,
  input  logic             din,
  output logic [SIG_W-1:0] q
);

  logic [SIG_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_seed)
      q_d = SEED;
    else if (shift_en)
      q_d = SIG_W'(sisr_next(64'(q_q), q_q[SIG_W-1] ^ din, 64'(POLY)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= SEED;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/sig_analyzer.sv
// Response compactor: FSM, pattern counter and golden compare around a sisr_reg.
// SIG_ANALYZER_ABORT_EN enables the abort input (RUN/COMPARE -> IDLE).
module sig_analyzer
  import sig_analyzer_pkg::*;
#(
  parameter int               SIG_W = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(SEED_DEF),
  parameter int               CNT_W = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  sig_analyzer_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] npat_q, npat_d;
  logic             pass_q, pass_d;
  logic             load_seed, shift_en, abort_req;
  logic [SIG_W-1:0] sig;

`ifdef SIG_ANALYZER_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  sisr_reg #(.SIG_W(SIG_W), .POLY(POLY), .SEED(SEED)) u_sisr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_seed (load_seed),
    .shift_en  (shift_en),
    .din       (bus.resp_bit),
    .q         (sig)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    npat_d    = npat_q;
    pass_d    = pass_q;
    load_seed = 1'b0;
    shift_en  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          load_seed = 1'b1;
          count_d   = '0;
          pass_d    = 1'b0;
          npat_d    = bus.num_patterns;
          state_d   = (bus.num_patterns == '0) ? COMPARE : RUN;
        end
      end
      RUN: begin
        // Abort wins over a response arriving in the same cycle.
        if (abort_req) begin
          state_d = IDLE;
        end else if (bus.resp_valid) begin
          shift_en = 1'b1;
          count_d  = count_q + CNT_W'(1);
          if (count_q == npat_q - CNT_W'(1))
            state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (abort_req) begin
          state_d = IDLE;
        end else begin
          pass_d  = (sig == bus.golden_sig);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      npat_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      npat_q  <= npat_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.busy      = (state_q == RUN) || (state_q == COMPARE);
  assign bus.done      = (state_q == DONE);
  assign bus.pass      = pass_q;
  assign bus.signature = sig;

endmodule
